// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD-line engine: oversamples host sd_clk/CMD, receives and checks 48-bit
// command frames, and transmits 48/136-bit responses with a serially computed CRC7.
`timescale 1ns/1ps
module neosd_card_cmd #(
  parameter int unsigned NCR         = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         sd_clk_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_idx_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_err_o,
  output logic         resp_ready_o,
  input  logic         resp_valid_i,
  input  logic [1:0]   resp_mode_i,
  input  logic [5:0]   resp_idx_i,
  input  logic [31:0]  resp_arg_i,
  input  logic [127:0] resp_data_i
);

  typedef enum logic [2:0] {StIdle, StRx, StCheck, StWait, StTx, StTxEnd} state_e;

  localparam logic [7:0] NcrCnt = 8'(NCR);

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  logic [SYNC_STAGES-1:0] r_clk_sync, r_cmd_sync;
  logic                   r_clk_prev;
  state_e                 r_state, w_state_d;
  logic [7:0]             r_cnt, w_cnt_d, r_rcnt, w_rcnt_d;
  logic [6:0]             r_crc, w_crc_d;
  logic [46:0]            r_rx, w_rx_d;
  logic [135:0]           r_tx, w_tx_d;
  logic [1:0]             r_mode, w_mode_d;
  logic                   r_cmd, w_cmd_d, r_oe, w_oe_d;
  logic                   r_valid, w_valid_d, r_err, w_err_d, r_ready, w_ready_d;
  logic [5:0]             r_idx, w_idx_d;
  logic [31:0]            r_arg, w_arg_d;
  logic                   w_clk_s, w_cmd_s, w_rise, w_fall, w_bit;
  logic [7:0]             w_len;
  logic                   w_unused_data;

  assign w_clk_s       = r_clk_sync[SYNC_STAGES-1];
  assign w_cmd_s       = r_cmd_sync[SYNC_STAGES-1];
  assign w_rise        = w_clk_s & ~r_clk_prev;
  assign w_fall        = ~w_clk_s & r_clk_prev;
  assign w_len         = (r_mode == 2'b11) ? 8'd136 : 8'd48;
  assign w_unused_data = ^resp_data_i[7:0];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_rcnt_d  = r_rcnt;
    w_crc_d   = r_crc;
    w_rx_d    = r_rx;
    w_tx_d    = r_tx;
    w_mode_d  = r_mode;
    w_cmd_d   = r_cmd;
    w_oe_d    = r_oe;
    w_idx_d   = r_idx;
    w_arg_d   = r_arg;
    w_valid_d = 1'b0;
    w_err_d   = 1'b0;
    w_ready_d = 1'b0;
    w_bit     = 1'b1;
    unique case (r_state)
      StIdle: begin
        w_oe_d  = 1'b0;
        w_cmd_d = 1'b1;
        if (w_rise && !w_cmd_s) begin
          w_rx_d    = '0;
          w_cnt_d   = 8'd1;
          w_crc_d   = '0;
          w_state_d = StRx;
        end
      end
      StRx: begin
        if (w_rise) begin
          w_rx_d  = {r_rx[45:0], w_cmd_s};
          w_cnt_d = r_cnt + 8'd1;
          if (r_cnt < 8'd40) w_crc_d = crc7_step(r_crc, w_cmd_s);
          if (r_cnt == 8'd47) w_state_d = StCheck;
        end
      end
      StCheck: begin
        if (r_rx[46] && r_rx[0] && (r_rx[7:1] == r_crc)) begin
          w_valid_d = 1'b1;
          w_idx_d   = r_rx[45:40];
          w_arg_d   = r_rx[39:8];
          w_rcnt_d  = '0;
          w_state_d = StWait;
        end else begin
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end
      end
      StWait: begin
        w_ready_d = 1'b1;
        if (w_rise && r_rcnt < NcrCnt) w_rcnt_d = r_rcnt + 8'd1;
        // A new start bit takes priority over a same-cycle response request
        if (w_rise && !w_cmd_s) begin
          w_ready_d = 1'b0;
          w_rx_d    = '0;
          w_cnt_d   = 8'd1;
          w_crc_d   = '0;
          w_state_d = StRx;
        end else if (resp_valid_i && r_ready) begin
          w_ready_d = 1'b0;
          w_mode_d  = resp_mode_i;
          w_cnt_d   = '0;
          w_crc_d   = '0;
          w_tx_d    = (resp_mode_i == 2'b11) ? {2'b00, 6'h3F, resp_data_i[127:8], 8'h00}
                                             : {2'b00, resp_idx_i, resp_arg_i, 96'h0};
          w_state_d = (resp_mode_i == 2'b00) ? StIdle : StTx;
        end
      end
      StTx: begin
        if (w_rise && !r_oe && r_rcnt < NcrCnt) w_rcnt_d = r_rcnt + 8'd1;
        if (w_fall && (r_oe || r_rcnt >= NcrCnt)) begin
          // Payload bits, then the CRC register shifted out, then the end bit
          if (r_cnt < w_len - 8'd8) begin
            w_bit  = r_tx[135];
            w_tx_d = {r_tx[134:0], 1'b0};
            if (r_mode != 2'b11 || r_cnt >= 8'd8) w_crc_d = crc7_step(r_crc, w_bit);
          end else if (r_cnt < w_len - 8'd1) begin
            w_bit   = (r_mode == 2'b10) ? 1'b1 : r_crc[6];
            w_crc_d = {r_crc[5:0], 1'b0};
          end else begin
            w_bit     = 1'b1;
            w_state_d = StTxEnd;
          end
          w_cmd_d = w_bit;
          w_oe_d  = 1'b1;
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StTxEnd: begin
        if (w_fall) begin
          w_oe_d    = 1'b0;
          w_cmd_d   = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_clk_sync <= '0;
      r_cmd_sync <= '1;
      r_clk_prev <= 1'b0;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_rcnt     <= '0;
      r_crc      <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_mode     <= '0;
      r_cmd      <= 1'b1;
      r_oe       <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
      r_idx      <= '0;
      r_arg      <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], sd_clk_i};
      r_cmd_sync <= {r_cmd_sync[SYNC_STAGES-2:0], sd_cmd_i};
      r_clk_prev <= w_clk_s;
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_rcnt     <= w_rcnt_d;
      r_crc      <= w_crc_d;
      r_rx       <= w_rx_d;
      r_tx       <= w_tx_d;
      r_mode     <= w_mode_d;
      r_cmd      <= w_cmd_d;
      r_oe       <= w_oe_d;
      r_valid    <= w_valid_d;
      r_err      <= w_err_d;
      r_ready    <= w_ready_d;
      r_idx      <= w_idx_d;
      r_arg      <= w_arg_d;
    end
  end

  assign sd_cmd_o     = r_cmd;
  assign sd_cmd_oe    = r_oe;
  assign cmd_valid_o  = r_valid;
  assign cmd_err_o    = r_err;
  assign resp_ready_o = r_ready;
  assign cmd_idx_o    = r_idx;
  assign cmd_arg_o    = r_arg;

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Directed self-checking bench for neosd_card_cmd: a host model drives command frames
// and captures response frames on the CMD line.
`timescale 1ns/1ps
module tb_neosd_card_cmd;

  logic         clk_i = 1'b0, rstn_i = 1'b0, sd_clk = 1'b0, sd_cmd_i = 1'b1;
  logic         sd_cmd_o, sd_cmd_oe, cmd_valid_o, cmd_err_o, resp_ready_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         resp_valid_i = 1'b0;
  logic [1:0]   resp_mode_i = '0;
  logic [5:0]   resp_idx_i = '0;
  logic [31:0]  resp_arg_i = '0;
  logic [127:0] resp_data_i = '0;

  neosd_card_cmd #(.NCR(2), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sd_clk_i(sd_clk), .sd_cmd_i(sd_cmd_i),
    .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .cmd_valid_o(cmd_valid_o),
    .cmd_idx_o(cmd_idx_o), .cmd_arg_o(cmd_arg_o), .cmd_err_o(cmd_err_o),
    .resp_ready_o(resp_ready_o), .resp_valid_i(resp_valid_i), .resp_mode_i(resp_mode_i),
    .resp_idx_i(resp_idx_i), .resp_arg_i(resp_arg_i), .resp_data_i(resp_data_i)
  );

  always #5 clk_i = ~clk_i;
  always #40 sd_clk = ~sd_clk;

  int n_total = 0, n_pass = 0;
  int rise_n = 0, cap_total = 0, start_rise = 0, end_rise = 0;
  int n_valid = 0, n_err = 0;
  logic [135:0] cap = '0;
  logic prev_oe = 1'b0;

  // Host-side capture of the card's CMD drive
  always @(posedge sd_clk) begin
    rise_n = rise_n + 1;
    if (sd_cmd_oe) begin
      cap = {cap[134:0], sd_cmd_o};
      cap_total = cap_total + 1;
      if (!prev_oe) start_rise = rise_n;
    end
    prev_oe = sd_cmd_oe;
  end

  always @(posedge clk_i) begin
    if (cmd_valid_o) n_valid = n_valid + 1;
    if (cmd_err_o) n_err = n_err + 1;
  end

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_total = n_total + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] crc7_bits(input logic [127:0] d, input int n);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] host_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [127:0] d;
    d = {88'h0, 2'b01, idx, arg};
    return {2'b01, idx, arg, crc7_bits(d, 40), 1'b1};
  endfunction

  task automatic send_bits(input logic [47:0] f, input int hi);
    for (int i = hi; i >= 0; i--) begin
      @(negedge sd_clk);
      sd_cmd_i = f[i];
    end
    @(posedge sd_clk);
    #1 end_rise = rise_n;
    @(negedge sd_clk);
    sd_cmd_i = 1'b1;
  endtask

  task automatic wait_cmd(input int v0, input int e0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i);
      #1;
      if (n_valid != v0 || n_err != e0) break;
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic respond(input logic [1:0] mode, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [127:0] data);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (resp_ready_o) break;
    end
    check("resp_ready_seen", resp_ready_o, 1'b1);
    resp_mode_i = mode; resp_idx_i = idx; resp_arg_i = arg; resp_data_i = data;
    resp_valid_i = 1'b1;
    @(negedge clk_i);
    resp_valid_i = 1'b0;
  endtask

  task automatic wait_frame(input int c0, input int len);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk_i);
      if (cap_total - c0 >= len && !sd_cmd_oe) break;
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int v0, e0, c0;
    logic [127:0] cid;
    logic [47:0]  f;

    #23;
    check("rst_oe", sd_cmd_oe, 1'b0);
    check("rst_cmd_o", sd_cmd_o, 1'b1);
    check("rst_valid", cmd_valid_o, 1'b0);
    check("rst_err", cmd_err_o, 1'b0);
    check("rst_ready", resp_ready_o, 1'b0);
    check("rst_idx", cmd_idx_o, 6'd0);
    check("rst_arg", cmd_arg_o, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (4) @(negedge sd_clk);

    // CMD0, no response
    v0 = n_valid; e0 = n_err; c0 = cap_total;
    send_bits(48'h400000000095, 47);
    wait_cmd(v0, e0);
    check("cmd0_valid", n_valid - v0, 1);
    check("cmd0_noerr", n_err - e0, 0);
    check("cmd0_idx", cmd_idx_o, 6'd0);
    check("cmd0_arg", cmd_arg_o, 32'd0);
    respond(2'b00, 6'd0, 32'd0, 128'd0);
    repeat (10) @(negedge sd_clk);
    check("cmd0_no_oe", cap_total - c0, 0);

    // CMD8 with R7-style short response
    v0 = n_valid; e0 = n_err;
    send_bits(48'h48000001AA87, 47);
    wait_cmd(v0, e0);
    check("cmd8_valid", n_valid - v0, 1);
    check("cmd8_idx", cmd_idx_o, 6'd8);
    check("cmd8_arg", cmd_arg_o, 32'h000001AA);
    c0 = cap_total;
    respond(2'b01, 6'd8, 32'h000001AA, 128'd0);
    wait_frame(c0, 48);
    check("r7_len", cap_total - c0, 48);
    check("r7_frame", cap[47:0], 48'h08000001AA13);
    check("r7_ncr", start_rise - end_rise, 3);
    check("r7_oe_off", sd_cmd_oe, 1'b0);
    check("r7_line_hi", sd_cmd_o, 1'b1);

    // Bad CRC
    v0 = n_valid; e0 = n_err; c0 = cap_total;
    send_bits(48'h48000001AA89, 47);
    wait_cmd(v0, e0);
    check("bad_err", n_err - e0, 1);
    check("bad_novalid", n_valid - v0, 0);
    repeat (20) @(negedge sd_clk);
    check("bad_no_oe", cap_total - c0, 0);

    // CMD2 with R2 long response
    v0 = n_valid; e0 = n_err;
    send_bits(host_frame(6'd2, 32'd0), 47);
    wait_cmd(v0, e0);
    check("cmd2_valid", n_valid - v0, 1);
    check("cmd2_idx", cmd_idx_o, 6'd2);
    cid = 128'h03534453443132388012345678012345;
    c0 = cap_total;
    respond(2'b11, 6'd0, 32'd0, cid);
    wait_frame(c0, 136);
    check("r2_len", cap_total - c0, 136);
    check("r2_header", cap[135:128], 8'h3F);
    check("r2_frame", cap, {8'h3F, cid[127:8], crc7_bits({8'h00, cid[127:8]}, 120), 1'b1});

    // CMD41 with R3 (CRC field forced high)
    v0 = n_valid; e0 = n_err;
    send_bits(host_frame(6'd41, 32'h40300000), 47);
    wait_cmd(v0, e0);
    check("cmd41_idx", cmd_idx_o, 6'd41);
    check("cmd41_arg", cmd_arg_o, 32'h40300000);
    c0 = cap_total;
    respond(2'b10, 6'h3F, 32'h80FF8000, 128'd0);
    wait_frame(c0, 48);
    check("r3_len", cap_total - c0, 48);
    check("r3_frame", cap[47:0], 48'h3F80FF8000FF);
    check("r3_crc_field", cap[7:1], 7'h7F);

    // New command while waiting for a response
    v0 = n_valid; e0 = n_err;
    send_bits(48'h48000001AA87, 47);
    wait_cmd(v0, e0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (resp_ready_o) break;
    end
    check("wait_ready_hi", resp_ready_o, 1'b1);
    v0 = n_valid; e0 = n_err; c0 = cap_total;
    f = 48'h400000000095;
    @(negedge sd_clk);
    sd_cmd_i = f[47];
    @(posedge sd_clk);
    #33;
    check("wait_ready_drop", resp_ready_o, 1'b0);
    send_bits(f, 46);
    wait_cmd(v0, e0);
    check("intr_valid", n_valid - v0, 1);
    check("intr_idx", cmd_idx_o, 6'd0);
    check("intr_arg", cmd_arg_o, 32'd0);
    respond(2'b00, 6'd0, 32'd0, 128'd0);
    repeat (6) @(negedge sd_clk);
    check("intr_no_oe", cap_total - c0, 0);

    // Reset in the middle of a response
    v0 = n_valid; e0 = n_err;
    send_bits(48'h400000000095, 47);
    wait_cmd(v0, e0);
    c0 = cap_total;
    respond(2'b01, 6'd0, 32'h00FF00FF, 128'd0);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk_i);
      if (cap_total - c0 >= 10) break;
    end
    #3;
    check("midtx_oe_before", sd_cmd_oe, 1'b1);
    rstn_i = 1'b0;
    #1;
    check("midtx_rst_oe", sd_cmd_oe, 1'b0);
    check("midtx_rst_cmd_o", sd_cmd_o, 1'b1);
    check("midtx_rst_ready", resp_ready_o, 1'b0);
    #50;
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (3) @(negedge sd_clk);
    v0 = n_valid; e0 = n_err;
    send_bits(48'h400000000095, 47);
    wait_cmd(v0, e0);
    check("post_rst_valid", n_valid - v0, 1);
    check("post_rst_noerr", n_err - e0, 0);
    check("post_rst_idx", cmd_idx_o, 6'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
